// File: rtl/handshake_monitor_pkg.sv
// Shared types for the valid/ready handshake monitor: channel FSM states,
// error event codes and a width helper.
package handshake_monitor_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    // Prefixed so the literals never collide with the TIMEOUT parameter.
    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_DROP    = 2'd1,
        ERR_DATA    = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_t;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/handshake_monitor_ch.sv
// One monitored valid/ready channel: stall FSM, payload capture, stall timer,
// saturating transfer counter, sticky error flags and a per-cycle event code.
module handshake_monitor_ch
    import handshake_monitor_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              ASYNCRESETN,
    input  logic              enable,
    input  logic              clear,
    input  logic              valid,
    input  logic              ready,
    input  logic [DATA_W-1:0] data,
    output logic [CNT_W-1:0]  xfer_count,
    output logic              err_drop,
    output logic              err_data,
    output logic              err_timeout,
    output err_code_t         ev_code
);

    localparam int unsigned SC_W = $clog2(TIMEOUT + 1);
    localparam logic [SC_W-1:0] TO_LIM = SC_W'(TIMEOUT);

    state_t            state;
    state_t            state_nx;
    logic [DATA_W-1:0] cap;
    logic [SC_W-1:0]   stall_cnt;
    logic [SC_W-1:0]   stall_nx;
    logic              cap_load;
    logic              xfer;
    logic              ev_drop;
    logic              ev_data;
    logic              ev_to;

    always_comb begin
        state_nx = state;
        stall_nx = stall_cnt;
        cap_load = 1'b0;
        xfer     = 1'b0;
        ev_drop  = 1'b0;
        ev_data  = 1'b0;
        ev_to    = 1'b0;
        case (state)
            IDLE: begin
                if (valid) begin
                    if (ready) begin
                        xfer = 1'b1;
                    end else begin
                        state_nx = STALL;
                        cap_load = 1'b1;
                        stall_nx = SC_W'(1);
                    end
                end
            end
            STALL: begin
                if (!valid) begin
                    ev_drop  = 1'b1;
                    state_nx = IDLE;
                    stall_nx = '0;
                end else begin
                    ev_data = (data != cap);
                    if (ready) begin
                        xfer     = 1'b1;
                        state_nx = IDLE;
                        stall_nx = '0;
                    end else if (stall_cnt != TO_LIM) begin
                        // Saturation at TO_LIM makes the timeout fire once per stall.
                        stall_nx = stall_cnt + SC_W'(1);
                        ev_to    = (stall_cnt == TO_LIM - SC_W'(1));
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ev_code = ERR_NONE;
        if (enable && !clear) begin
            if (ev_drop)      ev_code = ERR_DROP;
            else if (ev_data) ev_code = ERR_DATA;
            else if (ev_to)   ev_code = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state       <= IDLE;
            stall_cnt   <= '0;
            cap         <= '0;
            xfer_count  <= '0;
            err_drop    <= 1'b0;
            err_data    <= 1'b0;
            err_timeout <= 1'b0;
        end else if (enable) begin
            state     <= state_nx;
            stall_cnt <= stall_nx;
            if (cap_load) cap <= data;
            if (clear) begin
                xfer_count  <= '0;
                err_drop    <= 1'b0;
                err_data    <= 1'b0;
                err_timeout <= 1'b0;
            end else begin
                if (xfer && xfer_count != '1) xfer_count <= xfer_count + CNT_W'(1);
                err_drop    <= err_drop    | ev_drop;
                err_data    <= err_data    | ev_data;
                err_timeout <= err_timeout | ev_to;
            end
        end
    end

endmodule

// File: rtl/handshake_monitor.sv
// Passive protocol checker for NUM_CH valid/ready channels with per-channel
// counters/flags and a lowest-channel-wins first-error record.
module handshake_monitor
    import handshake_monitor_pkg::*;
#(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 64,
    localparam int unsigned CH_W   = clog2_min1(NUM_CH)
) (
    input  logic                     CLK,
    input  logic                     ASYNCRESETN,
    input  logic                     enable,
    input  logic                     clear,
    input  logic [NUM_CH-1:0]        valid,
    input  logic [NUM_CH-1:0]        ready,
    input  logic [NUM_CH*DATA_W-1:0] data,
    output logic [NUM_CH*CNT_W-1:0]  xfer_count,
    output logic [NUM_CH-1:0]        err_drop,
    output logic [NUM_CH-1:0]        err_data,
    output logic [NUM_CH-1:0]        err_timeout,
    output logic                     any_error,
    output logic                     first_err_valid,
    output logic [CH_W-1:0]          first_err_ch,
    output logic [1:0]               first_err_code
);

    err_code_t       ev [NUM_CH];
    logic            win_hit;
    logic [CH_W-1:0] win_ch;
    err_code_t       win_code;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        handshake_monitor_ch #(
            .DATA_W  (DATA_W),
            .CNT_W   (CNT_W),
            .TIMEOUT (TIMEOUT)
        ) u_ch (
            .CLK         (CLK),
            .ASYNCRESETN (ASYNCRESETN),
            .enable      (enable),
            .clear       (clear),
            .valid       (valid[i]),
            .ready       (ready[i]),
            .data        (data[i*DATA_W +: DATA_W]),
            .xfer_count  (xfer_count[i*CNT_W +: CNT_W]),
            .err_drop    (err_drop[i]),
            .err_data    (err_data[i]),
            .err_timeout (err_timeout[i]),
            .ev_code     (ev[i])
        );
    end

    always_comb begin
        win_hit  = 1'b0;
        win_ch   = '0;
        win_code = ERR_NONE;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!win_hit && ev[i] != ERR_NONE) begin
                win_hit  = 1'b1;
                win_ch   = CH_W'(i);
                win_code = ev[i];
            end
        end
    end

    assign any_error = |{err_drop, err_data, err_timeout};

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            first_err_valid <= 1'b0;
            first_err_ch    <= '0;
            first_err_code  <= '0;
        end else if (enable) begin
            if (clear) begin
                first_err_valid <= 1'b0;
                first_err_ch    <= '0;
                first_err_code  <= '0;
            end else if (!first_err_valid && win_hit) begin
                first_err_valid <= 1'b1;
                first_err_ch    <= win_ch;
                first_err_code  <= win_code;
            end
        end
    end

endmodule

// File: tb/tb_handshake_monitor.sv
// Randomised and directed bench for handshake_monitor against a transaction-level
// reference model of the valid/ready rules.
module tb_handshake_monitor;

    localparam int NCH  = 4;
    localparam int DW   = 8;
    localparam int CW   = 3;
    localparam int TO   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic             CLK = 1'b0;
    logic             ASYNCRESETN;
    logic             enable;
    logic             clear;
    logic [NCH-1:0]   valid;
    logic [NCH-1:0]   ready;
    logic [NCH*DW-1:0] data;
    logic [NCH*CW-1:0] xfer_count;
    logic [NCH-1:0]   err_drop;
    logic [NCH-1:0]   err_data;
    logic [NCH-1:0]   err_timeout;
    logic             any_error;
    logic             first_err_valid;
    logic [1:0]       first_err_ch;
    logic [1:0]       first_err_code;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a channel is either waiting on a held beat or not.
    bit       m_busy [NCH];
    bit [7:0] m_held [NCH];
    int       m_wait [NCH];
    int       m_cnt  [NCH];
    bit       m_drop [NCH];
    bit       m_dat  [NCH];
    bit       m_to   [NCH];
    bit       m_rec_v;
    int       m_rec_ch;
    int       m_rec_code;

    always #5 CLK = ~CLK;

    handshake_monitor #(
        .NUM_CH  (NCH),
        .DATA_W  (DW),
        .CNT_W   (CW),
        .TIMEOUT (TO)
    ) dut (
        .CLK             (CLK),
        .ASYNCRESETN     (ASYNCRESETN),
        .enable          (enable),
        .clear           (clear),
        .valid           (valid),
        .ready           (ready),
        .data            (data),
        .xfer_count      (xfer_count),
        .err_drop        (err_drop),
        .err_data        (err_data),
        .err_timeout     (err_timeout),
        .any_error       (any_error),
        .first_err_valid (first_err_valid),
        .first_err_ch    (first_err_ch),
        .first_err_code  (first_err_code)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_busy[c] = 0; m_held[c] = 0; m_wait[c] = 0; m_cnt[c] = 0;
            m_drop[c] = 0; m_dat[c] = 0; m_to[c] = 0;
        end
        m_rec_v = 0; m_rec_ch = 0; m_rec_code = 0;
    endtask

    task automatic model_step();
        bit ed, ea, et, xf;
        bit [7:0] d;
        if (!enable) return;
        for (int c = 0; c < NCH; c++) begin
            ed = 0; ea = 0; et = 0; xf = 0;
            d = data[c*DW +: DW];
            if (!m_busy[c]) begin
                if (valid[c] && ready[c]) xf = 1;
                else if (valid[c]) begin m_busy[c] = 1; m_held[c] = d; m_wait[c] = 1; end
            end else if (!valid[c]) begin
                ed = 1; m_busy[c] = 0; m_wait[c] = 0;
            end else begin
                ea = (d != m_held[c]);
                if (ready[c]) begin
                    xf = 1; m_busy[c] = 0; m_wait[c] = 0;
                end else if (m_wait[c] < TO) begin
                    m_wait[c]++;
                    et = (m_wait[c] == TO);
                end
            end
            if (!clear) begin
                if (xf && m_cnt[c] < CMAX) m_cnt[c]++;
                m_drop[c] |= ed; m_dat[c] |= ea; m_to[c] |= et;
                if (!m_rec_v && (ed || ea || et)) begin
                    m_rec_v = 1; m_rec_ch = c;
                    m_rec_code = ed ? 1 : (ea ? 2 : 3);
                end
            end
        end
        if (clear) model_reset_counters();
    endtask

    task automatic model_reset_counters();
        for (int c = 0; c < NCH; c++) begin
            m_cnt[c] = 0; m_drop[c] = 0; m_dat[c] = 0; m_to[c] = 0;
        end
        m_rec_v = 0; m_rec_ch = 0; m_rec_code = 0;
    endtask

    task automatic compare_all();
        logic [NCH-1:0] e_d, e_a, e_t;
        for (int c = 0; c < NCH; c++) begin
            check($sformatf("cnt%0d", c), 32'(xfer_count[c*CW +: CW]), 32'(m_cnt[c]));
            e_d[c] = m_drop[c]; e_a[c] = m_dat[c]; e_t[c] = m_to[c];
        end
        check("err_drop", 32'(err_drop), 32'(e_d));
        check("err_data", 32'(err_data), 32'(e_a));
        check("err_timeout", 32'(err_timeout), 32'(e_t));
        check("any_error", 32'(any_error), 32'(|{e_d, e_a, e_t}));
        check("rec_valid", 32'(first_err_valid), 32'(m_rec_v));
        check("rec_ch", 32'(first_err_ch), 32'(m_rec_ch));
        check("rec_code", 32'(first_err_code), 32'(m_rec_code));
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        compare_all();
    endtask

    task automatic idle_inputs();
        valid = '0; ready = '0; clear = 1'b0; enable = 1'b1;
    endtask

    task automatic do_clear();
        idle_inputs();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        ASYNCRESETN = 1'b0;
        enable = 1'b0; clear = 1'b0; valid = '0; ready = '0; data = '0;
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        check("reset_any", 32'(any_error), 0);
        check("reset_cnt", 32'(xfer_count), 0);
        check("reset_rec", 32'(first_err_valid), 0);
        ASYNCRESETN = 1'b1;
        idle_inputs();
        tick();

        // Five back-to-back transfers on ch2.
        valid = 4'b0100; ready = 4'b0100;
        for (int i = 0; i < 5; i++) begin data[2*DW +: DW] = 8'(i); tick(); end
        check("b2b_cnt2", 32'(xfer_count[2*CW +: CW]), 5);
        check("b2b_flags", 32'(any_error), 0);
        idle_inputs();
        tick();

        // Payload changes mid-stall on ch1.
        do_clear();
        valid = 4'b0010; data[1*DW +: DW] = 8'h3C;
        tick();
        tick();
        data[1*DW +: DW] = 8'h3D;
        tick();
        check("data_err1", 32'(err_data), 32'h2);
        check("data_rec_ch", 32'(first_err_ch), 1);
        check("data_rec_code", 32'(first_err_code), 2);
        ready = 4'b0010;
        tick();
        check("data_cnt1", 32'(xfer_count[1*CW +: CW]), 1);
        idle_inputs();
        tick();

        // Simultaneous drop on ch0 and ch3.
        do_clear();
        valid = 4'b1001;
        tick();
        valid = 4'b0000;
        tick();
        check("drop_flags", 32'(err_drop), 32'h9);
        check("drop_rec_ch", 32'(first_err_ch), 0);
        check("drop_rec_code", 32'(first_err_code), 1);

        // Long stall on ch0 against TIMEOUT.
        do_clear();
        valid = 4'b0001; data[0 +: DW] = 8'hA5;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check($sformatf("to_cyc%0d", i), 32'(err_timeout[0]), 32'(i >= TO));
        end
        check("to_rec_code", 32'(first_err_code), 3);
        ready = 4'b0001;
        tick();
        check("to_cnt0", 32'(xfer_count[0 +: CW]), 1);
        idle_inputs();
        tick();

        // Counter saturation, then a clear that swallows a transfer.
        do_clear();
        valid = 4'b1000; ready = 4'b1000;
        for (int i = 0; i < 9; i++) tick();
        check("sat_cnt3", 32'(xfer_count[3*CW +: CW]), CMAX);
        clear = 1'b1;
        tick();
        check("clr_cnt3", 32'(xfer_count[3*CW +: CW]), 0);
        idle_inputs();
        tick();
        check("clr_cnt3_hold", 32'(xfer_count[3*CW +: CW]), 0);

        // Drop while enable is low goes unreported.
        valid = 4'b0001; data[0 +: DW] = 8'h11;
        tick();
        enable = 1'b0; valid = 4'b0000;
        tick();
        check("en_low_drop", 32'(err_drop), 0);
        enable = 1'b1; valid = 4'b0001;
        tick();
        ready = 4'b0001;
        tick();
        idle_inputs();
        tick();

        // Asynchronous reset mid-stall, between clock edges.
        valid = 4'b0100; ready = 4'b0100;
        tick();
        valid = 4'b0010; ready = 4'b0000; data[1*DW +: DW] = 8'h01;
        tick();
        data[1*DW +: DW] = 8'h02;
        tick();
        #2;
        ASYNCRESETN = 1'b0;
        model_reset();
        #1;
        check("arst_cnt", 32'(xfer_count), 0);
        check("arst_flags", 32'({err_drop, err_data, err_timeout}), 0);
        check("arst_any", 32'(any_error), 0);
        check("arst_rec", 32'({first_err_valid, first_err_ch, first_err_code}), 0);
        valid = 4'b0000;
        #1;
        ASYNCRESETN = 1'b1;
        tick();
        check("arst_nodrop", 32'(err_drop), 0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            valid  = 4'($urandom);
            ready  = 4'($urandom);
            data   = $urandom & 32'h0303_0303;
            enable = ($urandom_range(0, 9) != 0);
            clear  = ($urandom_range(0, 39) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
